// File: rtl/regfile_mp.sv
// Multi-port register file: NRD reads, 2 prioritised writes, pending scoreboard.
// Post-reset sequential clear sweep; REGFILE_BYPASS_EN enables same-cycle write bypass.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [1:0]          wr_en,
  input  logic [2*AW-1:0]     wr_addr,
  input  logic [2*XLEN-1:0]   wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [NREGS-1:0]  pend_q, pend_d;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic [XLEN-1:0]   mem_d [NREGS];

  logic [AW-1:0]     wa [2];
  logic [XLEN-1:0]   wd [2];
  logic [1:0]        wv;
  logic              rsv_v;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wa[p] = wr_addr[p*AW +: AW];
      wd[p] = wr_data[p*XLEN +: XLEN];
      wv[p] = wr_en[p] && (wa[p] != '0) && (state_q == RUN);
    end
    rsv_v = rsv_en && (rsv_addr != '0) && (state_q == RUN);
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_d     = mem_q;
    pend_d    = pend_q;
    if (state_q == CLEAR) begin
      mem_d[clr_ptr_q] = '0;
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == AW'(NREGS-1))
        state_d = RUN;
    end else begin
      // port 1 applied last so it wins a collision
      for (int p = 0; p < 2; p++) begin
        if (wv[p]) begin
          mem_d[wa[p]]  = wd[p];
          pend_d[wa[p]] = 1'b0;
        end
      end
      // a new reservation outranks a retiring write
      if (rsv_v)
        pend_d[rsv_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= AW'(1);
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      pend_q    <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      mem_q <= mem_d;
  end

  assign ready = (state_q == RUN);

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] d;
    logic            b;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*AW +: AW];
      d  = mem_q[ra];
      b  = pend_q[ra];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < 2; p++) begin
        if (wv[p] && wa[p] == ra) begin
          d = wd[p];
          b = rsv_v && (rsv_addr == ra);
        end
      end
`endif
      if (state_q != RUN || ra == '0) begin
        d = '0;
        b = 1'b0;
      end
      rd_data[i*XLEN +: XLEN] = d;
      rd_busy[i] = b;
    end
  end

endmodule
